instruction_fetch_unit: RTL

- Initiator side of the instruction-memory read interface. Generates the address bus, tracks the one-cycle synchronous read latency, and presents fetched instructions to decode with a valid/stall handshake.
- Handles PC redirects from branch/jump/call/return resolution, halt requests and out-of-range fetch faults. Sits between the PC logic and decode in the IF stage.

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_perf_counters.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared IF-stage parameters and fetch FSM encoding.
// Decode and the PC/branch unit import this package as well.
package instruction_fetch_unit_pkg;

    localparam int IFU_ADDR_W    = 16;
    localparam int IFU_INSTR_W   = 16;
    localparam int IFU_MEM_DEPTH = 256;
    localparam int IFU_RESET_PC  = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_e;

    // Done in 32 bits so that a depth of exactly 2^ADDR_W still compares correctly.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_perf_counters.sv
// Free-running 32-bit performance counters for the fetch stage.
// They wrap at 2^32 and are cleared only by reset.
module fetch_perf_counters (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en_i,
    input  logic        stall_en_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (fetch_en_i ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + (stall_en_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign stall_count_o = stall_count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF-stage initiator for a one-cycle synchronous instruction memory.
// Issues addresses, tracks the word in flight, and hands it to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = IFU_ADDR_W,
    parameter int                INSTR_W   = IFU_INSTR_W,
    parameter int                MEM_DEPTH = IFU_MEM_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IFU_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus1,
    output logic               id_valid,
    input  logic               id_stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               halted,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic              rsp_valid_q;
    logic              fault_q;

    logic stalled;
    logic issue;
    logic pc_ok;
    logic redirect_ok;
    logic transfer;

    assign stalled     = rsp_valid_q & id_stall;
    assign issue       = (state_q == ST_RUN) & ~halt_req & ~stalled;
    assign pc_ok       = addr_in_range(32'(pc_q), MEM_DEPTH);
    assign redirect_ok = addr_in_range(32'(redirect_pc), MEM_DEPTH);
    assign transfer    = rsp_valid_q & ~id_stall & ~redirect_valid;

    // With no read enable on the memory, re-reading rsp_pc is what keeps imem_data stable.
    always_comb begin
        if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (issue) begin
            imem_addr = pc_q;
        end else begin
            imem_addr = rsp_pc_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else if (redirect_valid) begin
            if (redirect_ok) begin
                rsp_pc_q    <= redirect_pc;
                rsp_valid_q <= 1'b1;
                pc_q        <= redirect_pc + ADDR_W'(1);
                state_q     <= ST_RUN;
                fault_q     <= 1'b0;
            end else begin
                rsp_valid_q <= 1'b0;
                state_q     <= ST_FAULT;
                fault_q     <= 1'b1;
            end
        end else if (issue) begin
            if (pc_ok) begin
                rsp_pc_q    <= pc_q;
                rsp_valid_q <= 1'b1;
                pc_q        <= pc_q + ADDR_W'(1);
            end else begin
                rsp_valid_q <= 1'b0;
                state_q     <= ST_FAULT;
                fault_q     <= 1'b1;
            end
        end else if (!stalled) begin
            // Any word on display has just transferred, so the pipe is now empty.
            rsp_valid_q <= 1'b0;
            if (state_q == ST_RUN && halt_req) begin
                state_q <= ST_HALTED;
            end else if (state_q == ST_HALTED && !halt_req) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign id_valid    = rsp_valid_q;
    assign id_instr    = imem_data;
    assign id_pc       = rsp_pc_q;
    assign id_pc_plus1 = rsp_pc_q + ADDR_W'(1);
    assign halted      = (state_q == ST_HALTED);
    assign fetch_fault = fault_q;

    fetch_perf_counters u_perf (
        .clock         (clock),
        .reset         (reset),
        .fetch_en_i    (transfer),
        .stall_en_i    (stalled),
        .fetch_count_o (fetch_count),
        .stall_count_o (stall_count)
    );

endmodule
